changed_check_ctrl: RTL

Sequencer for sampled-value change checking on a watched signal. It captures the previous-cycle value, waits a programmable number of warm-up cycles after arming, then checks every cycle that the signal obeys the selected change rule ($changed, $stable, $rose or $fell semantics). It counts failures and halts after a failure budget is spent. It sits beside the stimulus logic in assertion-verification tops as a synthesizable, cycle-exact reference for concurrent change assertions.

---
 rtl/changed_check_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/changed_check_ctrl.sv
// Change-rule checker for a watched signal: arms on start, waits SKIP cycles,
// then checks $changed/$stable/$rose/$fell every cycle, counting failures.
module changed_check_ctrl #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SKIP     = 1,
    parameter int unsigned MAX_FAIL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] val,
    output logic             busy,
    output logic [31:0]      cyc,
    output logic             fail,
    output logic [15:0]      fail_count,
    output logic             done,
    output logic             halted
);

    localparam int unsigned CYC_W = 32;
    localparam int unsigned FC_W  = 16;
    localparam int unsigned SK_W  = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0] MODE_CHANGED = 2'b00;
    localparam logic [1:0] MODE_STABLE  = 2'b01;
    localparam logic [1:0] MODE_ROSE    = 2'b10;
    localparam logic [1:0] MODE_FELL    = 2'b11;

    localparam logic [FC_W-1:0] FC_SAT     = {FC_W{1'b1}};
    localparam logic [FC_W-1:0] FAIL_LIMIT = FC_W'(MAX_FAIL);
    localparam logic [SK_W-1:0] SKIP_LOAD  = SK_W'(SKIP);
    localparam logic            HALT_EN    = (MAX_FAIL != 0);

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [FC_W-1:0]  fail_count_q, fail_count_d;
    logic [SK_W-1:0]  skip_q, skip_d;
    logic             busy_q, busy_d;
    logic             fail_q, fail_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;

    logic             rule_ok_c;
    logic             arm_c;
    logic [FC_W-1:0]  fail_count_inc_c;

    // Rule evaluation on the current sample against the previous one.
    always_comb begin
        rule_ok_c = 1'b1;
        case (mode_q)
            MODE_CHANGED: rule_ok_c = (val != prev_q);
            MODE_STABLE:  rule_ok_c = (val == prev_q);
            MODE_ROSE:    rule_ok_c = !prev_q[0] && val[0];
            MODE_FELL:    rule_ok_c = prev_q[0] && !val[0];
            default:      rule_ok_c = 1'b1;
        endcase
    end

    assign arm_c            = start && !stop;
    assign fail_count_inc_c = (fail_count_q == FC_SAT) ? fail_count_q
                                                       : fail_count_q + FC_W'(1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        prev_d       = prev_q;
        cyc_d        = cyc_q;
        fail_count_d = fail_count_q;
        skip_d       = skip_q;
        busy_d       = busy_q;
        fail_d       = 1'b0;
        done_d       = 1'b0;
        halted_d     = halted_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (arm_c) begin
                    mode_d       = mode;
                    prev_d       = val;
                    cyc_d        = '0;
                    fail_count_d = '0;
                    skip_d       = SKIP_LOAD;
                    busy_d       = 1'b1;
                    halted_d     = 1'b0;
                    state_d      = (SKIP_LOAD == '0) ? ST_CHECK : ST_SKIP;
                end
            end

            ST_SKIP: begin
                prev_d = val;
                cyc_d  = cyc_q + CYC_W'(1);
                skip_d = skip_q - SK_W'(1);
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (skip_q <= SK_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                prev_d = val;
                cyc_d  = cyc_q + CYC_W'(1);
                if (!rule_ok_c) begin
                    fail_d       = 1'b1;
                    fail_count_d = fail_count_inc_c;
                end
                // A stop in the same cycle still counts the failure but wins over HALT.
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (HALT_EN && !rule_ok_c && (fail_count_inc_c == FAIL_LIMIT)) begin
                    state_d  = ST_HALT;
                    busy_d   = 1'b0;
                    halted_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_CHANGED;
            prev_q       <= '0;
            cyc_q        <= '0;
            fail_count_q <= '0;
            skip_q       <= '0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            prev_q       <= prev_d;
            cyc_q        <= cyc_d;
            fail_count_q <= fail_count_d;
            skip_q       <= skip_d;
            busy_q       <= busy_d;
            fail_q       <= fail_d;
            done_q       <= done_d;
            halted_q     <= halted_d;
        end
    end

    assign busy       = busy_q;
    assign cyc        = cyc_q;
    assign fail       = fail_q;
    assign fail_count = fail_count_q;
    assign done       = done_q;
    assign halted     = halted_q;

endmodule
